// File: rtl/rtc_bus_ctrl_if.sv
// Pin and request bundle between the PicoBlaze port registers, the RTC
// bus master and the RTC pads. master = bus controller, slave = its user/pads.
interface rtc_bus_ctrl_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 8
);
    localparam int unsigned IDX_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    // request side (PicoBlaze port registers)
    logic              start_rd;
    logic              start_wr;
    logic [IDX_W:0]    burst_len;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    // RTC pad side
    logic [DATA_W-1:0] ad_in;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic              A_D;
    logic              CS;
    logic              RD;
    logic              WR;

    // status and read results
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              rd_valid;
    logic [IDX_W-1:0]  rd_idx;
    logic              bcd_err;

    modport master (
        input  start_rd, start_wr, burst_len, addr, wdata, ad_in,
        output ad_out, ad_oe, A_D, CS, RD, WR,
        output busy, done, rdata, rd_valid, rd_idx, bcd_err
    );

    modport slave (
        output start_rd, start_wr, burst_len, addr, wdata, ad_in,
        input  ad_out, ad_oe, A_D, CS, RD, WR,
        input  busy, done, rdata, rd_valid, rd_idx, bcd_err
    );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Bus master for a multiplexed A_D/CS/RD/WR RTC: single write, single read
// and burst read of consecutive registers with indexed result strobes.
// Optional macro RTC_BCD_CHECK_EN builds a sticky BCD check on read data;
// without it bcd_err is tied low.
module rtc_bus_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned T_PHASE   = 4,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    rtc_bus_ctrl_if.master bus
);
    localparam int unsigned IDX_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int unsigned LEN_W = IDX_W + 1;
    localparam int unsigned CNT_W = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(T_PHASE - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(BURST_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_HOLD,
        S_DATA,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              op_wr, op_wr_nxt;
    logic [DATA_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [LEN_W-1:0]  remain, remain_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [LEN_W-1:0]  len_clamped;
    logic              last;
    logic              sample;

    logic [DATA_W-1:0] ad_out_q, ad_out_nxt;
    logic              ad_oe_q, ad_oe_nxt;
    logic              a_d_q, a_d_nxt;
    logic              cs_q, cs_nxt;
    logic              rd_q, rd_nxt;
    logic              wr_q, wr_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic              rd_valid_q, rd_valid_nxt;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_nxt;

    assign last = (cnt == '0);

    // Burst length: 0 means single, oversize requests saturate at BURST_MAX
    always_comb begin
        len_clamped = bus.burst_len;
        if (bus.burst_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (bus.burst_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    // Next state, transaction context and pin values for the state being entered
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        op_wr_nxt    = op_wr;
        addr_nxt     = addr_q;
        wdata_nxt    = wdata_q;
        remain_nxt   = remain;
        idx_nxt      = idx;
        sample       = 1'b0;
        rdata_nxt    = rdata_q;
        rd_idx_nxt   = rd_idx_q;
        rd_valid_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start_wr || bus.start_rd) begin
                    state_nxt  = S_ADDR;
                    op_wr_nxt  = bus.start_wr;
                    addr_nxt   = bus.addr;
                    wdata_nxt  = bus.wdata;
                    idx_nxt    = '0;
                    remain_nxt = bus.start_wr ? '0 : (len_clamped - LEN_W'(1));
                end
            end
            S_ADDR: begin
                if (last) state_nxt = S_ADDR_HOLD;
            end
            S_ADDR_HOLD: begin
                if (last) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (last) begin
                    state_nxt = S_RECOVER;
                    sample    = !op_wr;
                end
            end
            S_RECOVER: begin
                if (last) begin
                    if (!op_wr && (remain != '0)) begin
                        state_nxt  = S_ADDR;
                        addr_nxt   = addr_q + DATA_W'(1);
                        idx_nxt    = idx + IDX_W'(1);
                        remain_nxt = remain - LEN_W'(1);
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // every state entry restarts the phase timer
        if (state_nxt != state) begin
            cnt_nxt = CNT_LOAD;
        end else if (state != S_IDLE) begin
            cnt_nxt = cnt - CNT_W'(1);
        end

        if (sample) begin
            rdata_nxt    = bus.ad_in;
            rd_idx_nxt   = idx;
            rd_valid_nxt = 1'b1;
        end

        // pins are decoded from the next state so they change with the state
        cs_nxt     = 1'b1;
        rd_nxt     = 1'b1;
        wr_nxt     = 1'b1;
        a_d_nxt    = 1'b1;
        ad_oe_nxt  = 1'b0;
        ad_out_nxt = '0;
        busy_nxt   = (state_nxt != S_IDLE);
        done_nxt   = (state_nxt == S_DONE);

        case (state_nxt)
            S_ADDR: begin
                cs_nxt     = 1'b0;
                a_d_nxt    = 1'b0;
                wr_nxt     = 1'b0;
                ad_oe_nxt  = 1'b1;
                ad_out_nxt = addr_nxt;
            end
            S_ADDR_HOLD: begin
                cs_nxt     = 1'b0;
                a_d_nxt    = 1'b0;
                ad_oe_nxt  = 1'b1;
                ad_out_nxt = addr_nxt;
            end
            S_DATA: begin
                cs_nxt = 1'b0;
                if (op_wr_nxt) begin
                    wr_nxt     = 1'b0;
                    ad_oe_nxt  = 1'b1;
                    ad_out_nxt = wdata_nxt;
                end else begin
                    rd_nxt = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // State, context and registered pin/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= CNT_LOAD;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            remain     <= '0;
            idx        <= '0;
            ad_out_q   <= '0;
            ad_oe_q    <= 1'b0;
            a_d_q      <= 1'b1;
            cs_q       <= 1'b1;
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            op_wr      <= op_wr_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            remain     <= remain_nxt;
            idx        <= idx_nxt;
            ad_out_q   <= ad_out_nxt;
            ad_oe_q    <= ad_oe_nxt;
            a_d_q      <= a_d_nxt;
            cs_q       <= cs_nxt;
            rd_q       <= rd_nxt;
            wr_q       <= wr_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            rdata_q    <= rdata_nxt;
            rd_valid_q <= rd_valid_nxt;
            rd_idx_q   <= rd_idx_nxt;
        end
    end

    assign bus.ad_out   = ad_out_q;
    assign bus.ad_oe    = ad_oe_q;
    assign bus.A_D      = a_d_q;
    assign bus.CS       = cs_q;
    assign bus.RD       = rd_q;
    assign bus.WR       = wr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_idx   = rd_idx_q;

`ifdef RTC_BCD_CHECK_EN
    logic accept;
    logic bcd_err_q, bcd_err_nxt;

    assign accept = (state == S_IDLE) && (bus.start_wr || bus.start_rd);

    function automatic logic has_bad_nibble(input logic [DATA_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned n = 0; n < DATA_W / 4; n++) begin
            if (v[n*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Sticky BCD flag: cleared by a new request, set by any non-BCD read sample
    always_comb begin
        bcd_err_nxt = bcd_err_q;
        if (accept) begin
            bcd_err_nxt = 1'b0;
        end else if (sample && has_bad_nibble(bus.ad_in)) begin
            bcd_err_nxt = 1'b1;
        end
    end

    // BCD flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_err_q <= 1'b0;
        end else begin
            bcd_err_q <= bcd_err_nxt;
        end
    end

    assign bus.bcd_err = bcd_err_q;
`else
    assign bus.bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl (T_PHASE=2): stimulus pushes expected
// bus phases and result events; negedge monitors pop and compare.
module tb_rtc_bus_ctrl;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned T_PHASE   = 2;
    localparam int unsigned BURST_MAX = 8;
    localparam int          ACC_CYC   = 4 * T_PHASE;
`ifdef RTC_BCD_CHECK_EN
    localparam bit BCD_ON = 1'b1;
`else
    localparam bit BCD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_bus_ctrl_if #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) bus ();

    rtc_bus_ctrl #(
        .DATA_W   (DATA_W),
        .T_PHASE  (T_PHASE),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit         is_done;
        logic [7:0] data;
        logic [2:0] idx;
        bit         bcd;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] addr;
        bit         wr;
        logic [7:0] wdata;
    } ph_t;

    ev_t        ev_q[$];
    ph_t        ph_q[$];
    logic [7:0] mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ph(input logic [7:0] a, input bit wr, input logic [7:0] wd);
        ph_t p;
        p.addr = a; p.wr = wr; p.wdata = wd;
        ph_q.push_back(p);
    endtask

    task automatic push_rd(input logic [7:0] d, input logic [2:0] i, input bit bcd);
        ev_t e;
        e.is_done = 1'b0; e.data = d; e.idx = i; e.bcd = bcd; e.cyc = 0;
        ev_q.push_back(e);
    endtask

    // issue one request; nacc>0 also queues the expected done cycle
    task automatic req(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] wd,
                       input logic [3:0] blen, input int nacc);
        ev_t e;
        @(negedge clk);
        if (nacc > 0) begin
            e.is_done = 1'b1; e.data = '0; e.idx = '0; e.bcd = 1'b0;
            e.cyc = cyc + 1 + ACC_CYC * nacc;
            ev_q.push_back(e);
        end
        bus.start_wr = wr; bus.start_rd = rd; bus.addr = a; bus.wdata = wd; bus.burst_len = blen;
        @(negedge clk);
        bus.start_wr = 1'b0; bus.start_rd = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((bus.busy || ev_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            fails++;
            $display("FAIL idle_timeout: busy=%0b, %0d events outstanding after %0d cycles", bus.busy, ev_q.size(), n);
        end
        @(negedge clk);
    endtask

    // RTC model: latch address during the address phase and present its byte
    always @(negedge clk) begin
        if (reset && !bus.CS && !bus.A_D) bus.ad_in = mem[bus.ad_out];
    end

    ev_t cur_ev;
    ph_t cur_ph;
    int  alen = 0;
    int  dlen = 0;
    bit  prev_cs = 1'b1;
    bit  prev_ad = 1'b1;

    // Monitor: pin protocol, phase contents/lengths, result and done events
    always @(negedge clk) begin
        if (!reset) begin
            alen = 0; dlen = 0; prev_cs = 1'b1; prev_ad = 1'b1;
        end else begin
            checks++;
            if ((!bus.RD && !bus.WR) || (bus.ad_oe && !bus.RD)) begin
                fails++;
                $display("FAIL strobe_rule: RD=%0b WR=%0b ad_oe=%0b at cycle %0d", bus.RD, bus.WR, bus.ad_oe, cyc);
            end

            if (!bus.CS && !bus.A_D && (prev_cs || prev_ad)) begin
                if (ph_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_access: address 0x%0h with nothing pending", bus.ad_out);
                    cur_ph.addr = bus.ad_out; cur_ph.wr = 1'b0; cur_ph.wdata = '0;
                end else begin
                    cur_ph = ph_q.pop_front();
                    chk("addr_value", 32'(bus.ad_out), 32'(cur_ph.addr));
                    chk("addr_wr_low", 32'(bus.WR), 32'(0));
                    chk("addr_oe", 32'(bus.ad_oe), 32'(1));
                end
            end
            if (!bus.CS && bus.A_D && !prev_cs && !prev_ad) begin
                if (cur_ph.wr) begin
                    chk("wr_data", 32'(bus.ad_out), 32'(cur_ph.wdata));
                    chk("wr_strobe", 32'({bus.WR, bus.RD, bus.ad_oe}), 32'(3'b011));
                end else begin
                    chk("rd_strobe", 32'({bus.WR, bus.RD, bus.ad_oe}), 32'(3'b100));
                end
            end

            if (!bus.CS && !bus.A_D && !bus.WR) alen++;
            else if (alen != 0) begin chk("addr_len", 32'(alen), 32'(T_PHASE)); alen = 0; end
            if (!bus.CS && bus.A_D) dlen++;
            else if (dlen != 0) begin chk("data_len", 32'(dlen), 32'(T_PHASE)); dlen = 0; end

            if (bus.rd_valid) begin
                if (ev_q.size() == 0 || ev_q[0].is_done) begin
                    checks++; fails++;
                    $display("FAIL unexpected_rd_valid: rdata 0x%0h idx %0d", bus.rdata, bus.rd_idx);
                end else begin
                    cur_ev = ev_q.pop_front();
                    chk("rdata", 32'(bus.rdata), 32'(cur_ev.data));
                    chk("rd_idx", 32'(bus.rd_idx), 32'(cur_ev.idx));
                    chk("bcd_err_at_read", 32'(bus.bcd_err), 32'(cur_ev.bcd));
                end
            end
            if (bus.done) begin
                if (ev_q.size() == 0 || !ev_q[0].is_done) begin
                    checks++; fails++;
                    $display("FAIL unexpected_done: at cycle %0d, %0d events pending", cyc, ev_q.size());
                end else begin
                    cur_ev = ev_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(cur_ev.cyc));
                end
            end
            prev_cs = bus.CS;
            prev_ad = bus.A_D;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h02] = 8'h37;
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;
        mem[8'h00] = 8'h33;
        mem[8'h03] = 8'h08;
        mem[8'h10] = 8'h5A;
        mem[8'h11] = 8'h59;
        for (int i = 0; i < 8; i++) mem[8'h20 + i] = 8'h40 + 8'(i);

        reset = 1'b0;
        bus.start_rd = 1'b0; bus.start_wr = 1'b0; bus.burst_len = '0;
        bus.addr = '0; bus.wdata = '0; bus.ad_in = '0;

        repeat (3) @(negedge clk);
        chk("reset_strobes", 32'({bus.CS, bus.RD, bus.WR, bus.A_D, bus.ad_oe}), 32'(5'b11110));
        chk("reset_ad_out", 32'(bus.ad_out), 32'(0));
        chk("reset_status", 32'({bus.busy, bus.done, bus.rd_valid, bus.bcd_err}), 32'(0));
        chk("reset_rdata", 32'({bus.rdata, bus.rd_idx}), 32'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single write 0x45 -> 0x00
        push_ph(8'h00, 1'b1, 8'h45);
        req(1'b1, 1'b0, 8'h00, 8'h45, 4'd0, 1);
        chk("busy_after_accept", 32'(bus.busy), 32'(1));
        wait_idle(40);
        chk("busy_after_done", 32'(bus.busy), 32'(0));

        // single read of 0x02
        push_ph(8'h02, 1'b0, 8'h00);
        push_rd(8'h37, 3'd0, 1'b0);
        req(1'b0, 1'b1, 8'h02, 8'h00, 4'd1, 1);
        wait_idle(40);

        // burst of 3 wrapping 0xFE -> 0x00
        push_ph(8'hFE, 1'b0, 8'h00);
        push_ph(8'hFF, 1'b0, 8'h00);
        push_ph(8'h00, 1'b0, 8'h00);
        push_rd(8'h11, 3'd0, 1'b0);
        push_rd(8'h22, 3'd1, 1'b0);
        push_rd(8'h33, 3'd2, 1'b0);
        req(1'b0, 1'b1, 8'hFE, 8'h00, 4'd3, 3);
        wait_idle(80);

        // both starts: write wins; a read pulse while busy is ignored
        push_ph(8'h05, 1'b1, 8'hA5);
        req(1'b1, 1'b1, 8'h05, 8'hA5, 4'd3, 1);
        repeat (2) @(negedge clk);
        bus.start_rd = 1'b1; bus.addr = 8'h02;
        @(negedge clk);
        bus.start_rd = 1'b0;
        wait_idle(40);
        chk("rdata_held", 32'(bus.rdata), 32'(8'h33));

        // burst_len 0 acts as single
        push_ph(8'h02, 1'b0, 8'h00);
        push_rd(8'h37, 3'd0, 1'b0);
        req(1'b0, 1'b1, 8'h02, 8'h00, 4'd0, 1);
        wait_idle(40);

        // burst_len 15 clamps to 8
        for (int i = 0; i < 8; i++) begin
            push_ph(8'h20 + 8'(i), 1'b0, 8'h00);
            push_rd(8'h40 + 8'(i), 3'(i), 1'b0);
        end
        req(1'b0, 1'b1, 8'h20, 8'h00, 4'd15, 8);
        wait_idle(150);

        // BCD flag: 0x5A sets it (when built), next request clears it
        push_ph(8'h10, 1'b0, 8'h00);
        push_rd(8'h5A, 3'd0, BCD_ON);
        req(1'b0, 1'b1, 8'h10, 8'h00, 4'd1, 1);
        wait_idle(40);
        chk("bcd_sticky", 32'(bus.bcd_err), 32'(BCD_ON));
        push_ph(8'h11, 1'b0, 8'h00);
        push_rd(8'h59, 3'd0, 1'b0);
        req(1'b0, 1'b1, 8'h11, 8'h00, 4'd1, 1);
        chk("bcd_clear_on_accept", 32'(bus.bcd_err), 32'(0));
        wait_idle(40);
        chk("bcd_after_good_read", 32'(bus.bcd_err), 32'(0));

        // reset in the middle of a read data phase
        push_ph(8'h03, 1'b0, 8'h00);
        req(1'b0, 1'b1, 8'h03, 8'h00, 4'd1, 0);
        n = 0;
        while (bus.RD && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_data_phase", 32'(bus.RD), 32'(0));
        #2 reset = 1'b0;
        #1;
        chk("abort_strobes", 32'({bus.CS, bus.RD, bus.WR, bus.A_D, bus.ad_oe}), 32'(5'b11110));
        chk("abort_busy", 32'(bus.busy), 32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        chk("events_left", 32'(ev_q.size()), 32'(0));
        chk("phases_left", 32'(ph_q.size()), 32'(0));
        chk("final_bcd", 32'(bus.bcd_err), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
